// File: rtl/addr_seq.sv
// Row serial-number sequencer feeding the queue address selector.
// Sweeps 0..SEQ_LAST per tile, parks at IDLE_VAL during the drain gap, and flags tile/job completion.
module addr_seq #(
    parameter int ARRAY_SIZE     = 8,
    parameter int QUEUE_SIZE     = 4,
    parameter int QUEUE_COUNT    = (ARRAY_SIZE + 3) / 4,
    parameter int ROW_LAST       = 98,
    parameter int SEQ_LAST       = ROW_LAST + (QUEUE_COUNT - 1) * QUEUE_SIZE,
    parameter int ADDR_WIDTH_MIN = 7,
    parameter int IDLE_VAL       = (1 << ADDR_WIDTH_MIN) - 1,
    parameter int DRAIN_CYCLES   = 2 * ARRAY_SIZE,
    parameter int TILE_W         = 4
) (
    input  logic                      clk,
    input  logic                      srstn,
    input  logic                      start,
    input  logic [TILE_W-1:0]         tile_num,
    input  logic                      stall,
    output logic [ADDR_WIDTH_MIN-1:0] addr_serial_num,
    output logic                      seq_valid,
    output logic [TILE_W-1:0]         tile_idx,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      done
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_WIDTH_MIN-1:0] SERIAL_LAST = ADDR_WIDTH_MIN'(SEQ_LAST);
    localparam logic [ADDR_WIDTH_MIN-1:0] SERIAL_IDLE = ADDR_WIDTH_MIN'(IDLE_VAL);
    localparam logic [CNT_W-1:0]          DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

    // The parked value must never collide with a live row, or the selector would fetch during drain.
    if (SEQ_LAST < 0 || SEQ_LAST >= IDLE_VAL) begin : g_bad_seq_last
        $error("addr_seq: SEQ_LAST must lie in [0, IDLE_VAL)");
    end
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
        $error("addr_seq: DRAIN_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                      r_state;
    logic [ADDR_WIDTH_MIN-1:0]   r_serial;
    logic                        r_valid;
    logic [TILE_W-1:0]           r_tileIdx;
    logic [TILE_W-1:0]           r_tileLast;
    logic [CNT_W-1:0]            r_drainCnt;
    logic                        r_busy;
    logic                        r_tileDone;
    logic                        r_done;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state    <= IDLE;
            r_serial   <= SERIAL_IDLE;
            r_valid    <= 1'b0;
            r_tileIdx  <= '0;
            r_tileLast <= '0;
            r_drainCnt <= '0;
            r_busy     <= 1'b0;
            r_tileDone <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tileDone <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tileLast <= tile_num;
                        r_tileIdx  <= '0;
                        r_serial   <= '0;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (r_serial == SERIAL_LAST) begin
                            r_serial   <= SERIAL_IDLE;
                            r_valid    <= 1'b0;
                            r_drainCnt <= '0;
                            r_state    <= DRAIN;
                        end else begin
                            r_serial <= r_serial + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The next tile begins on the same edge that reports the previous one done.
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_tileDone <= 1'b1;
                        if (r_tileIdx == r_tileLast) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_tileIdx <= r_tileIdx + 1'b1;
                            r_serial  <= '0;
                            r_valid   <= 1'b1;
                            r_state   <= RUN;
                        end
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_serial <= SERIAL_IDLE;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign addr_serial_num = r_serial;
    assign seq_valid       = r_valid;
    assign tile_idx        = r_tileIdx;
    assign busy            = r_busy;
    assign tile_done       = r_tileDone;
    assign done            = r_done;

endmodule

// File: tb/tb_addr_seq.sv
// Bench for addr_seq: a tile-phase reference model feeds a scoreboard checked every cycle,
// a table of jobs with hand-computed completion cycles, and hand-written reset/restart sequences.
module tb_addr_seq;

    localparam int SEQ_LAST = 102;
    localparam int DRAIN    = 16;
    localparam int PERIOD   = SEQ_LAST + 1 + DRAIN;
    localparam int IDLE_VAL = 127;

    logic       clk = 1'b0;
    logic       srstn;
    logic       start;
    logic [3:0] tile_num;
    logic       stall;
    logic [6:0] addr_serial_num;
    logic       seq_valid;
    logic [3:0] tile_idx;
    logic       busy;
    logic       tile_done;
    logic       done;

    typedef struct {
        logic [6:0] serial;
        logic       valid;
        logic [3:0] tileIdx;
        logic       busy;
        logic       tileDone;
        logic       done;
    } exp_t;

    typedef struct {
        logic [3:0] tileNum;
        int         stallFrom;
        int         stallLen;
        int         busyStartAt;
        int         expDone;
    } job_t;

    exp_t sbQueue[$];
    job_t jobs[5];
    int   checks = 0;
    int   errors = 0;

    bit   mActive;
    int   mPhase;
    int   mTile;
    int   mLast;

    addr_seq dut (
        .clk             (clk),
        .srstn           (srstn),
        .start           (start),
        .tile_num        (tile_num),
        .stall           (stall),
        .addr_serial_num (addr_serial_num),
        .seq_valid       (seq_valid),
        .tile_idx        (tile_idx),
        .busy            (busy),
        .tile_done       (tile_done),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mActive = 1'b0;
        mPhase  = 0;
        mTile   = 0;
        mLast   = 0;
        sbQueue.delete();
    endtask

    // Track position within the tile period; live rows occupy phases 0..SEQ_LAST, drain the rest.
    task automatic modelStep(input logic s, input logic st, input logic [3:0] tn);
        exp_t e;
        e.tileDone = 1'b0;
        e.done     = 1'b0;
        if (!mActive) begin
            if (s) begin
                mActive = 1'b1;
                mPhase  = 0;
                mTile   = 0;
                mLast   = int'(tn);
            end
        end else if (!(mPhase <= SEQ_LAST && st)) begin
            mPhase++;
            if (mPhase == PERIOD) begin
                e.tileDone = 1'b1;
                if (mTile == mLast) begin
                    e.done  = 1'b1;
                    mActive = 1'b0;
                end else begin
                    mTile++;
                    mPhase = 0;
                end
            end
        end
        e.valid   = mActive && (mPhase <= SEQ_LAST);
        e.serial  = e.valid ? 7'(mPhase) : 7'(IDLE_VAL);
        e.busy    = mActive;
        e.tileIdx = 4'(mTile);
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: queue empty, expected one entry");
        end else begin
            e = sbQueue.pop_front();
            checkVal("serial", 32'(addr_serial_num), 32'(e.serial));
            checkVal("seq_valid", 32'(seq_valid), 32'(e.valid));
            checkVal("tile_idx", 32'(tile_idx), 32'(e.tileIdx));
            checkVal("busy", 32'(busy), 32'(e.busy));
            checkVal("tile_done", 32'(tile_done), 32'(e.tileDone));
            checkVal("done", 32'(done), 32'(e.done));
        end
    endtask

    task automatic applyStimulus(input logic s, input logic st);
        start = s;
        stall = st;
        modelStep(s, st, tile_num);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, " serial"}, 32'(addr_serial_num), 32'(IDLE_VAL));
        checkVal({tag, " seq_valid"}, 32'(seq_valid), 32'd0);
        checkVal({tag, " tile_idx"}, 32'(tile_idx), 32'd0);
        checkVal({tag, " busy"}, 32'(busy), 32'd0);
        checkVal({tag, " tile_done"}, 32'(tile_done), 32'd0);
        checkVal({tag, " done"}, 32'(done), 32'd0);
    endtask

    task automatic runJob(input job_t j);
        int doneCycle;
        int tdCount;
        logic s;
        logic st;
        doneCycle = -1;
        tdCount   = 0;
        tile_num  = j.tileNum;
        for (int k = 0; k <= j.expDone + 3; k++) begin
            s  = (k == 0) || (k == j.busyStartAt);
            st = (j.stallFrom >= 0) && (k >= j.stallFrom) && (k < j.stallFrom + j.stallLen);
            applyStimulus(s, st);
            if (tile_done === 1'b1) tdCount++;
            if (done === 1'b1 && doneCycle < 0) doneCycle = k + 1;
        end
        checkVal("job done cycle", 32'(doneCycle), 32'(j.expDone));
        checkVal("job tile_done count", 32'(tdCount), 32'(int'(j.tileNum) + 1));
    endtask

    initial begin
        srstn    = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;
        tile_num = 4'd0;
        modelReset();

        jobs[0] = '{tileNum: 4'd0, stallFrom: -1,  stallLen: 0,  busyStartAt: -1,  expDone: 120};
        jobs[1] = '{tileNum: 4'd2, stallFrom: -1,  stallLen: 0,  busyStartAt: -1,  expDone: 358};
        jobs[2] = '{tileNum: 4'd0, stallFrom: 50,  stallLen: 5,  busyStartAt: -1,  expDone: 125};
        jobs[3] = '{tileNum: 4'd0, stallFrom: 105, stallLen: 10, busyStartAt: 30,  expDone: 120};
        jobs[4] = '{tileNum: 4'd1, stallFrom: 60,  stallLen: 3,  busyStartAt: 200, expDone: 242};

        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        srstn = 1'b1;
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0);

        foreach (jobs[i]) runJob(jobs[i]);

        // A start on the edge that raises done is dropped; the following one is taken.
        tile_num = 4'd0;
        for (int k = 0; k < 119; k++) applyStimulus(k == 0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkVal("start at done edge: done", 32'(done), 32'd1);
        checkVal("start at done edge: busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkVal("restart: serial", 32'(addr_serial_num), 32'd0);
        checkVal("restart: busy", 32'(busy), 32'd1);
        for (int k = 0; k < 59; k++) applyStimulus(1'b0, 1'b0);
        checkVal("mid-job serial", 32'(addr_serial_num), 32'd59);

        #2;
        srstn = 1'b0;
        #1;
        checkResetValues("async reset");
        modelReset();
        @(posedge clk);
        #1;
        checkResetValues("held reset");
        @(negedge clk);
        srstn = 1'b1;
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0);

        runJob(jobs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
